spi_ram: RTL and testbench

//   Single-port 256x8 synchronous RAM controlled by 10-bit command words from the SPI slave.
//   din[9:8] is the opcode and din[7:0] is the address or data payload.

---
 rtl/ram_pkg.sv | 12 +
 rtl/spi_ram.sv | 46 ++++
 tb/tb_spi_ram.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared opcode encodings and default geometry for the SPI-controlled RAM.
package ram_pkg;

  localparam logic [1:0] OP_RD_ADDR = 2'b00;
  localparam logic [1:0] OP_RD_DATA = 2'b01;
  localparam logic [1:0] OP_WR_ADDR = 2'b10;
  localparam logic [1:0] OP_WR_DATA = 2'b11;

  localparam int DEFAULT_MEM_DEPTH = 256;
  localparam int DEFAULT_ADDR_SIZE = $clog2(DEFAULT_MEM_DEPTH);

endpackage

// File: rtl/spi_ram.sv
// 256x8 single-port RAM driven by 10-bit SPI command words ({opcode, payload}).
module spi_ram
  import ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic [9:0] din,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  // Left unreset so benches can preload contents through dut.MEM[i].
  reg [7:0] MEM [0:MEM_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      // tx_valid is a strobe: only an accepted read-data command raises it.
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (din[9:8])
          OP_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
          OP_RD_DATA: begin
            dout     <= MEM[rd_addr];
            tx_valid <= 1'b1;
          end
          OP_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
          OP_WR_DATA: MEM[wr_addr] <= din[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a spec model feeds a queue of expected read data.
module tb_spi_ram;

  logic [9:0] din;
  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [0:255];
  logic [7:0] m_rd;
  logic [7:0] m_wr;
  logic [7:0] m_dout;
  logic [7:0] sb [$];

  spi_ram dut (
    .din     (din),
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_valid(rx_valid),
    .dout    (dout),
    .tx_valid(tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command, advance one edge, then compare outputs against the model.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl, input logic rv);
    logic [7:0] exp;
    logic       exp_tx;
    din      = {op, pl};
    rx_valid = rv;
    @(posedge clk);
    #1;
    exp_tx = rv && (op == 2'b01);
    if (rv) begin
      case (op)
        2'b00: m_rd = pl;
        2'b01: sb.push_back(m_mem[m_rd]);
        2'b10: m_wr = pl;
        2'b11: m_mem[m_wr] = pl;
        default: ;
      endcase
    end
    check8("tx_valid", {7'd0, tx_valid}, {7'd0, exp_tx});
    if (exp_tx) begin
      if (sb.size() == 0) begin
        check8("sb_underflow", 8'd1, 8'd0);
      end else begin
        exp    = sb.pop_front();
        m_dout = exp;
        check8("read_data", dout, exp);
      end
    end else begin
      check8("dout_hold", dout, m_dout);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    din      = '0;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    m_rd     = '0;
    m_wr     = '0;
    m_dout   = '0;

    // 1. Reset
    repeat (5) @(posedge clk);
    #1;
    check8("rst_dout", dout, 8'h00);
    check8("rst_tx", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check8("post_rst_dout", dout, 8'h00);
    check8("post_rst_tx", {7'd0, tx_valid}, 8'h00);

    // 2. Gated commands over a preloaded memory
    for (int i = 0; i < 256; i++) begin
      dut.MEM[i] = 8'(i);
      m_mem[i]   = 8'(i);
    end
    for (int i = 0; i < 256; i++) begin
      cmd(2'b00, 8'(i), 1'b0);
      cmd(2'b01, 8'($urandom), 1'b0);
    end
    for (int i = 0; i < 256; i += 17) check8("mem_unchanged", dut.MEM[i], m_mem[i]);

    // 3. Sequential read of every address
    for (int i = 0; i < 256; i++) begin
      cmd(2'b00, 8'(i), 1'b1);
      cmd(2'b01, 8'($urandom), 1'b1);
    end
    cmd(2'b00, 8'h07, 1'b0);

    // 4. Write then read back, fixed then random (avoiding 0x00 and 0x10)
    cmd(2'b10, 8'h3C, 1'b1);
    cmd(2'b11, 8'hA5, 1'b1);
    cmd(2'b00, 8'h3C, 1'b1);
    cmd(2'b01, 8'h00, 1'b1);
    check8("wr_rd_3c", dout, 8'hA5);
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom_range(8'h40, 8'hFF));
      d = 8'($urandom);
      cmd(2'b10, a, 1'b1);
      cmd(2'b11, d, 1'b1);
      cmd(2'b00, a, 1'b1);
      cmd(2'b01, 8'($urandom), 1'b1);
      check8("wr_rd_rand", dout, d);
    end
    // Repeated reads reuse rd_addr.
    cmd(2'b01, 8'h00, 1'b1);

    // 5. Gated write must not land
    cmd(2'b10, 8'h10, 1'b0);
    cmd(2'b11, 8'hFF, 1'b0);
    cmd(2'b00, 8'h10, 1'b1);
    cmd(2'b01, 8'h00, 1'b1);
    check8("gated_wr", dout, 8'h10);

    // 6. Reset mid-operation: address registers return to 0
    cmd(2'b10, 8'h00, 1'b1);
    cmd(2'b11, 8'h5A, 1'b1);
    cmd(2'b00, 8'h20, 1'b1);
    rst_n = 1'b0;
    #2;
    check8("async_rst_dout", dout, 8'h00);
    check8("async_rst_tx", {7'd0, tx_valid}, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    m_rd   = '0;
    m_wr   = '0;
    m_dout = '0;
    cmd(2'b01, 8'h00, 1'b1);
    check8("rst_rd_mem0", dout, 8'h5A);
    cmd(2'b00, 8'h00, 1'b0);

    check8("sb_empty", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
